sensor_debounce_multi: RTL and testbench
========================================

// Module: sensor_debounce_multi
// PURPOSE
//  Multi-channel sensor input conditioner: per-channel 2-flop synchroniser, asymmetric
//  debounce (separate assert/release qualification times), one-cycle edge events and a
//  sticky "stuck active" fault flag. Sits between raw sensor pins and the control FSMs,
//  replacing per-sensor single-channel debouncers.
// PARAMETERS
//  CHANNELS     4      number of independent sensor channels (>=1)
//  ASSERT_CNT   50000  consecutive active samples required to assert (>=1)
//  RELEASE_CNT  10000  consecutive inactive samples required to release (>=1)
//  ACTIVE_LOW   1      1: pin level 0 = active; 0: pin level 1 = active
//  STUCK_CNT    0      cycles continuously asserted before stuck flag sets; 0 = disabled
// PORTS
//  clk            in   1         system clock, all logic on posedge
//  reset          in   1         asynchronous, active-high reset
//  sensor_in      in   CHANNELS  raw asynchronous sensor pins
//  clear_stuck    in   CHANNELS  per-channel stuck-flag clear, level sampled each clk
//  sensor_out     out  CHANNELS  debounced level, pin polarity (inactive = ~ACTIVE_LOW... i.e. ACTIVE_LOW)
//  active         out  CHANNELS  debounced level, active-high
//  assert_pulse   out  CHANNELS  1-cycle pulse when channel becomes active
//  release_pulse  out  CHANNELS  1-cycle pulse when channel becomes inactive
//  stuck          out  CHANNELS  sticky fault: channel held active >= STUCK_CNT cycles
//  any_active     out  1         OR of active
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops = inactive pin level; active=0;
//   sensor_out = ACTIVE_LOW ? all-1 : all-0; pulses=0; stuck=0; any_active=0; counters=0.
//   Reset mid-count discards all progress; no pulse on reset entry or exit.
//  Sync: s1<=pin, s2<=s1 per channel; raw_act = s2 ^ ACTIVE_LOW. Logic sees only s2.
//  Per-channel 2-state FSM, state bit = active: INACTIVE(0) / ACTIVE(1).
//  Qualify counter cnt, width $clog2(max(ASSERT_CNT,RELEASE_CNT)+1):
//   - raw_act == state: cnt <= 0 (strictly consecutive; any glitch restarts timing).
//   - raw_act != state, INACTIVE: if cnt == ASSERT_CNT-1 -> state<=1, cnt<=0,
//     assert_pulse<=1; else cnt<=cnt+1.
//   - raw_act != state, ACTIVE: if cnt == RELEASE_CNT-1 -> state<=0, cnt<=0,
//     release_pulse<=1; else cnt<=cnt+1.
//  Latency: pin edge to active/sensor_out/pulse = 2 + ASSERT_CNT clk (assert),
//   2 + RELEASE_CNT clk (release). Pulses are registered, aligned with level change,
//   exactly one cycle wide; assert and release never pulse in same cycle on a channel.
//  sensor_out = active ^ ACTIVE_LOW (registered equivalent); any_active = |active,
//   registered, same cycle as active.
//  Stuck (STUCK_CNT>0): hold counter counts while active=1, saturates at STUCK_CNT,
//   clears to 0 when active=0. stuck sets the cycle hold reaches STUCK_CNT; cleared by
//   clear_stuck only. Simultaneous set condition and clear: set wins, so stuck cannot be
//   cleared while channel is still saturated-active. STUCK_CNT=0: stuck tied 0, no counter.
//  Channels fully independent; simultaneous events on several channels all reported in
//  the same cycle. No counter wraps: cnt never exceeds max-1, hold saturates.
// TESTING  (CHANNELS=4, ASSERT_CNT=8, RELEASE_CNT=5, ACTIVE_LOW=1, STUCK_CNT=20)
//  1 Reset: drive ch0 low 5 cycles, pulse reset -> sensor_out=4'b1111, active=0, no pulses;
//    after release ch0 still low -> asserts 8 cycles after first post-reset s2 sample.
//  2 Clean press ch0: pin 1->0 held -> active[0]=1, sensor_out[0]=0, assert_pulse[0]
//    high exactly one cycle, all on the 10th clk edge after pin edge.
//  3 Bounce: ch0 low 7, high 1, low held -> no assert at 7; assert 10 clk after last
//    falling edge; no spurious pulses on ch1..3.
//  4 Release: ch0 active, pin high 4 cycles, low 1, high held -> release_pulse[0] one
//    cycle 7 clk after final rising edge; sensor_out[0]=1 same cycle.
//  5 Simultaneous: ch1, ch2 fall same cycle -> assert_pulse=4'b0110 same cycle,
//    any_active=1; release only ch1 -> any_active stays 1.
//  6 Stuck: hold ch3 active -> stuck[3]=1 when hold reaches 20; clear_stuck[3] while
//    held -> stays 1; release ch3, then clear_stuck[3] -> stuck[3]=0 next cycle.

Source files
------------

// File: rtl/sensor_debounce_multi.sv
// Multi-channel sensor conditioner: 2-flop sync, asymmetric debounce, edge pulses
// and a sticky stuck-active flag per channel.
module sensor_debounce_multi #(
  parameter int CHANNELS    = 4,
  parameter int ASSERT_CNT  = 50000,
  parameter int RELEASE_CNT = 10000,
  parameter int ACTIVE_LOW  = 1,
  parameter int STUCK_CNT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sensor_in,
  input  logic [CHANNELS-1:0] clear_stuck,
  output logic [CHANNELS-1:0] sensor_out,
  output logic [CHANNELS-1:0] active,
  output logic [CHANNELS-1:0] assert_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] stuck,
  output logic                any_active
);

  // state       | meaning
  // ST_INACTIVE | debounced channel inactive, qualifying toward assert
  // ST_ACTIVE   | debounced channel active, qualifying toward release
  typedef enum logic {ST_INACTIVE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  localparam int MAX_CNT = (ASSERT_CNT > RELEASE_CNT) ? ASSERT_CNT : RELEASE_CNT;
  localparam int CW = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] ASSERT_TC  = CW'(ASSERT_CNT - 1);
  localparam logic [CW-1:0] RELEASE_TC = CW'(RELEASE_CNT - 1);
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0);

  logic [CHANNELS-1:0] act_nxt;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic          s1, s2, raw_act, is_active, flip;
    logic          ap_q, rp_q, so_q;
    state_t        state;
    logic [CW-1:0] cnt, tc;

    assign raw_act    = s2 ^ IDLE_PIN;
    assign is_active  = (state == ST_ACTIVE);
    assign tc         = is_active ? RELEASE_TC : ASSERT_TC;
    assign flip       = (raw_act != is_active) && (cnt == tc);
    assign act_nxt[g] = is_active ^ flip;

    assign active[g]        = is_active;
    assign sensor_out[g]    = so_q;
    assign assert_pulse[g]  = ap_q;
    assign release_pulse[g] = rp_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1    <= IDLE_PIN;
        s2    <= IDLE_PIN;
        state <= ST_INACTIVE;
        cnt   <= '0;
        ap_q  <= 1'b0;
        rp_q  <= 1'b0;
        so_q  <= IDLE_PIN;
      end else begin
        s1   <= sensor_in[g];
        s2   <= s1;
        ap_q <= 1'b0;
        rp_q <= 1'b0;
        so_q <= act_nxt[g] ^ IDLE_PIN;
        if (raw_act == is_active) begin
          cnt <= '0;
        end else if (cnt == tc) begin
          cnt <= '0;
          case (state)
            ST_ACTIVE: begin
              state <= ST_INACTIVE;
              rp_q  <= 1'b1;
            end
            default: begin
              state <= ST_ACTIVE;
              ap_q  <= 1'b1;
            end
          endcase
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    if (STUCK_CNT > 0) begin : g_stuck
      localparam int HW = $clog2(STUCK_CNT + 1);
      localparam logic [HW-1:0] STUCK_TC = HW'(STUCK_CNT);
      logic [HW-1:0] hold;
      logic          stk, hold_sat, set_stk;

      assign hold_sat = (hold == STUCK_TC);
      // set fires on the edge hold reaches the limit and keeps firing while saturated
      assign set_stk  = is_active && (hold_sat || (hold == STUCK_TC - 1'b1));
      assign stuck[g] = stk;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold <= '0;
          stk  <= 1'b0;
        end else begin
          if (!is_active)    hold <= '0;
          else if (!hold_sat) hold <= hold + 1'b1;
          if (set_stk)             stk <= 1'b1;
          else if (clear_stuck[g]) stk <= 1'b0;
        end
      end
    end else begin : g_no_stuck
      logic unused_clear;
      assign unused_clear = clear_stuck[g];
      assign stuck[g]     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_active <= 1'b0;
    else       any_active <= |act_nxt;
  end

endmodule

// File: tb/tb_sensor_debounce_multi.sv
// Directed bench for sensor_debounce_multi (4 ch, assert 8, release 5, active-low, stuck 20).
module tb_sensor_debounce_multi;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sensor_in, clear_stuck;
  logic [3:0] sensor_out, active, assert_pulse, release_pulse, stuck;
  logic       any_active;
  int         total = 0;
  int         bad = 0;

  sensor_debounce_multi #(
    .CHANNELS(4), .ASSERT_CNT(8), .RELEASE_CNT(5), .ACTIVE_LOW(1), .STUCK_CNT(20)
  ) dut (
    .clk(clk), .reset(reset), .sensor_in(sensor_in), .clear_stuck(clear_stuck),
    .sensor_out(sensor_out), .active(active), .assert_pulse(assert_pulse),
    .release_pulse(release_pulse), .stuck(stuck), .any_active(any_active)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_so"}, 32'(sensor_out), 32'hF);
    chk({tag, "_act"}, 32'(active), 32'h0);
    chk({tag, "_ap"}, 32'(assert_pulse), 32'h0);
    chk({tag, "_rp"}, 32'(release_pulse), 32'h0);
    chk({tag, "_stk"}, 32'(stuck), 32'h0);
    chk({tag, "_any"}, 32'(any_active), 32'h0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    sensor_in = 4'hF;
    clear_stuck = 4'h0;
    step(2);
    reset = 1'b0;
    step(1);
    chk_reset_state("rst0");

    // reset mid-count discards progress
    sensor_in = 4'b1110;
    step(5);
    reset = 1'b1;
    #1;
    chk_reset_state("rst_mid");
    step(2);
    reset = 1'b0;
    step(9);
    chk("rst_pre_assert", 32'(active), 32'h0);
    step(1);
    chk("rst_assert_act", 32'(active), 32'h1);
    chk("rst_assert_ap", 32'(assert_pulse), 32'h1);
    chk("rst_assert_so", 32'(sensor_out), 32'hE);
    chk("rst_assert_any", 32'(any_active), 32'h1);
    step(1);
    chk("rst_ap_width", 32'(assert_pulse), 32'h0);

    // clean release
    sensor_in = 4'hF;
    step(6);
    chk("rel_pre", 32'(active), 32'h1);
    step(1);
    chk("rel_rp", 32'(release_pulse), 32'h1);
    chk("rel_so", 32'(sensor_out), 32'hF);
    chk("rel_ap_none", 32'(assert_pulse), 32'h0);
    step(1);
    chk("rel_rp_width", 32'(release_pulse), 32'h0);

    // bounce: low 7, high 1, low held
    sensor_in = 4'b1110;
    step(7);
    chk("bnc_at7_act", 32'(active), 32'h0);
    sensor_in = 4'hF;
    step(1);
    sensor_in = 4'b1110;
    step(9);
    chk("bnc_pre_act", 32'(active), 32'h0);
    chk("bnc_pre_ap", 32'(assert_pulse), 32'h0);
    step(1);
    chk("bnc_ap", 32'(assert_pulse), 32'h1);
    chk("bnc_act", 32'(active), 32'h1);

    // release with bounce: high 4, low 1, high held
    sensor_in = 4'hF;
    step(4);
    sensor_in = 4'b1110;
    step(1);
    sensor_in = 4'hF;
    step(6);
    chk("rbnc_pre_act", 32'(active), 32'h1);
    chk("rbnc_pre_rp", 32'(release_pulse), 32'h0);
    step(1);
    chk("rbnc_rp", 32'(release_pulse), 32'h1);
    chk("rbnc_so", 32'(sensor_out), 32'hF);
    step(1);
    chk("rbnc_rp_width", 32'(release_pulse), 32'h0);

    // clean press on ch0
    sensor_in = 4'b1110;
    step(9);
    chk("prs_pre", 32'(active), 32'h0);
    step(1);
    chk("prs_ap", 32'(assert_pulse), 32'h1);
    chk("prs_so", 32'(sensor_out), 32'hE);
    sensor_in = 4'hF;
    step(7);
    chk("prs_rel", 32'(active), 32'h0);

    // simultaneous ch1/ch2
    sensor_in = 4'b1001;
    step(9);
    chk("sim_pre", 32'(assert_pulse), 32'h0);
    step(1);
    chk("sim_ap", 32'(assert_pulse), 32'h6);
    chk("sim_act", 32'(active), 32'h6);
    chk("sim_any", 32'(any_active), 32'h1);
    sensor_in = 4'b1011;
    step(7);
    chk("sim_rp1", 32'(release_pulse), 32'h2);
    chk("sim_act2", 32'(active), 32'h4);
    chk("sim_any_held", 32'(any_active), 32'h1);
    sensor_in = 4'hF;
    step(7);
    chk("sim_rp2", 32'(release_pulse), 32'h4);
    chk("sim_any_off", 32'(any_active), 32'h0);

    // stuck on ch3
    sensor_in = 4'b0111;
    step(10);
    chk("stk_act", 32'(active), 32'h8);
    step(19);
    chk("stk_pre", 32'(stuck[3]), 32'h0);
    step(1);
    chk("stk_set", 32'(stuck[3]), 32'h1);
    clear_stuck = 4'b1000;
    step(2);
    chk("stk_clr_held", 32'(stuck[3]), 32'h1);
    clear_stuck = 4'h0;
    sensor_in = 4'hF;
    step(7);
    chk("stk_rel", 32'(active), 32'h0);
    chk("stk_sticky", 32'(stuck[3]), 32'h1);
    clear_stuck = 4'b1000;
    step(1);
    chk("stk_cleared", 32'(stuck[3]), 32'h0);
    clear_stuck = 4'h0;
    step(1);
    chk("stk_final", 32'(stuck), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
